// File: rtl/sdram_axi_master.sv
// AXI4 burst initiator: one command at a time becomes a single AR/R or AW/W/B burst.
// Address phase starts one cycle after accept; R/W data pass through combinationally; done one cycle after last handshake.
module sdram_axi_master #(
    parameter int ID_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_write_i,
    input  logic [31:0]     req_addr_i,
    input  logic [7:0]      req_len_i,
    input  logic [1:0]      req_burst_i,
    input  logic [ID_W-1:0] req_id_i,
    input  logic            wr_valid_i,
    input  logic [31:0]     wr_data_i,
    input  logic [3:0]      wr_strb_i,
    output logic            wr_ready_o,
    output logic            rd_valid_o,
    output logic [31:0]     rd_data_o,
    output logic            rd_last_o,
    input  logic            rd_ready_i,
    output logic            done_o,
    output logic            error_o,
    output logic            busy_o,
    output logic            axi_awvalid_o,
    output logic [31:0]     axi_awaddr_o,
    output logic [ID_W-1:0] axi_awid_o,
    output logic [7:0]      axi_awlen_o,
    output logic [1:0]      axi_awburst_o,
    input  logic            axi_awready_i,
    output logic            axi_wvalid_o,
    output logic [31:0]     axi_wdata_o,
    output logic [3:0]      axi_wstrb_o,
    output logic            axi_wlast_o,
    input  logic            axi_wready_i,
    input  logic            axi_bvalid_i,
    input  logic [1:0]      axi_bresp_i,
    input  logic [ID_W-1:0] axi_bid_i,
    output logic            axi_bready_o,
    output logic            axi_arvalid_o,
    output logic [31:0]     axi_araddr_o,
    output logic [ID_W-1:0] axi_arid_o,
    output logic [7:0]      axi_arlen_o,
    output logic [1:0]      axi_arburst_o,
    input  logic            axi_arready_i,
    input  logic            axi_rvalid_i,
    input  logic [31:0]     axi_rdata_i,
    input  logic [1:0]      axi_rresp_i,
    input  logic [ID_W-1:0] axi_rid_i,
    input  logic            axi_rlast_i,
    output logic            axi_rready_o
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q;
    logic [7:0]      len_q;
    logic [1:0]      burst_q;
    logic [ID_W-1:0] id_q;
    logic [7:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            accept, r_hs, w_hs, cnt_zero;

    assign accept   = req_valid_i && (state_q == S_IDLE);
    assign cnt_zero = (cnt_q == 8'd0);
    assign r_hs     = (state_q == S_R) && axi_rvalid_i && rd_ready_i;
    assign w_hs     = (state_q == S_W) && wr_valid_i && axi_wready_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (req_valid_i) begin
                state_d = req_write_i ? S_AW : S_AR;
                cnt_d   = req_len_i;
                err_d   = 1'b0;
            end
            S_AR: if (axi_arready_i) state_d = S_R;
            S_R: if (r_hs) begin
                // Early rlast and missing rlast are both protocol errors; the burst ends on either.
                if ((axi_rresp_i != 2'b00) || (axi_rid_i != id_q) ||
                    (axi_rlast_i != cnt_zero))
                    err_d = 1'b1;
                if (!cnt_zero)
                    cnt_d = cnt_q - 8'd1;
                if (cnt_zero || axi_rlast_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_AW: if (axi_awready_i) state_d = S_W;
            S_W: if (w_hs) begin
                if (cnt_zero) state_d = S_B;
                else          cnt_d   = cnt_q - 8'd1;
            end
            S_B: if (axi_bvalid_i) begin
                if ((axi_bresp_i != 2'b00) || (axi_bid_i != id_q))
                    err_d = 1'b1;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= 32'd0;
            len_q   <= 8'd0;
            burst_q <= 2'd0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            if (accept) begin
                addr_q  <= req_addr_i;
                len_q   <= req_len_i;
                burst_q <= req_burst_i;
                id_q    <= req_id_i;
            end
        end
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign error_o       = done_q && err_q;

    assign axi_arvalid_o = (state_q == S_AR);
    assign axi_araddr_o  = addr_q;
    assign axi_arid_o    = id_q;
    assign axi_arlen_o   = len_q;
    assign axi_arburst_o = burst_q;
    assign axi_awvalid_o = (state_q == S_AW);
    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = id_q;
    assign axi_awlen_o   = len_q;
    assign axi_awburst_o = burst_q;

    // Data paths are gated by state so nothing leaks onto either stream outside its burst.
    assign axi_wvalid_o  = (state_q == S_W) && wr_valid_i;
    assign axi_wdata_o   = (state_q == S_W) ? wr_data_i : 32'd0;
    assign axi_wstrb_o   = (state_q == S_W) ? wr_strb_i : 4'd0;
    assign axi_wlast_o   = (state_q == S_W) && cnt_zero;
    assign wr_ready_o    = (state_q == S_W) && axi_wready_i;
    assign axi_bready_o  = (state_q == S_B);

    assign axi_rready_o  = (state_q == S_R) && rd_ready_i;
    assign rd_valid_o    = (state_q == S_R) && axi_rvalid_i;
    assign rd_data_o     = (state_q == S_R) ? axi_rdata_i : 32'd0;
    assign rd_last_o     = (state_q == S_R) && axi_rvalid_i && cnt_zero;
endmodule

// File: tb/tb_sdram_axi_master.sv
// Bench for sdram_axi_master: drives commands and plays the AXI slave, scoreboarding R and W beats.
module tb_sdram_axi_master;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [31:0] req_addr_i;
    logic [7:0]  req_len_i;
    logic [1:0]  req_burst_i;
    logic [3:0]  req_id_i;
    logic        wr_valid_i, wr_ready_o;
    logic [31:0] wr_data_i;
    logic [3:0]  wr_strb_i;
    logic        rd_valid_o, rd_last_o, rd_ready_i;
    logic [31:0] rd_data_o;
    logic        done_o, error_o, busy_o;
    logic        axi_awvalid_o, axi_awready_i;
    logic [31:0] axi_awaddr_o;
    logic [3:0]  axi_awid_o;
    logic [7:0]  axi_awlen_o;
    logic [1:0]  axi_awburst_o;
    logic        axi_wvalid_o, axi_wlast_o, axi_wready_i;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_bvalid_i, axi_bready_o;
    logic [1:0]  axi_bresp_i;
    logic [3:0]  axi_bid_i;
    logic        axi_arvalid_o, axi_arready_i;
    logic [31:0] axi_araddr_o;
    logic [3:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_rvalid_i, axi_rlast_i, axi_rready_o;
    logic [31:0] axi_rdata_i;
    logic [1:0]  axi_rresp_i;
    logic [3:0]  axi_rid_i;

    int n_chk = 0;
    int n_err = 0;
    logic [32:0] rq[$];
    logic [36:0] wq[$];

    always #5 clk_i = ~clk_i;

    sdram_axi_master #(.ID_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_burst_i(req_burst_i), .req_id_i(req_id_i),
        .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i), .wr_ready_o(wr_ready_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .rd_ready_i(rd_ready_i),
        .done_o(done_o), .error_o(error_o), .busy_o(busy_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
        .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
        .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
        .axi_wlast_o(axi_wlast_o), .axi_wready_i(axi_wready_i),
        .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
        .axi_bready_o(axi_bready_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
        .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o), .axi_arready_i(axi_arready_i),
        .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i), .axi_rready_o(axi_rready_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdat(input logic [3:0] id, input int n);
        return 32'hD000_0000 | (32'(id) << 16) | 32'(n);
    endfunction

    function automatic logic [31:0] wdat(input int n);
        return 32'h5A00_0000 ^ (32'(n) * 32'h0001_0101);
    endfunction

    function automatic logic [3:0] wstb(input int n);
        return 4'hF ^ 4'(n & 3);
    endfunction

    task automatic idle_inputs();
        req_valid_i = 0; req_write_i = 0; req_addr_i = 0; req_len_i = 0; req_burst_i = 0; req_id_i = 0;
        wr_valid_i = 0; wr_data_i = 0; wr_strb_i = 0; rd_ready_i = 0;
        axi_awready_i = 0; axi_wready_i = 0; axi_bvalid_i = 0; axi_bresp_i = 0; axi_bid_i = 0;
        axi_arready_i = 0; axi_rvalid_i = 0; axi_rdata_i = 0; axi_rresp_i = 0; axi_rid_i = 0; axi_rlast_i = 0;
    endtask

    // Starts at a cycle boundary (posedge+1); returns at posedge+1 of the cycle after accept.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        req_valid_i = 1; req_write_i = wr; req_addr_i = addr; req_len_i = len;
        req_burst_i = 2'b01; req_id_i = id;
        @(negedge clk_i);
        chk("req_ready_idle", 64'(req_ready_o), 64'(1));
        @(posedge clk_i); #1;
        req_valid_i = 0;
        chk(wr ? "awvalid_n1" : "arvalid_n1", 64'(wr ? axi_awvalid_o : axi_arvalid_o), 64'(1));
        chk("busy_n1", 64'(busy_o), 64'(1));
    endtask

    task automatic finish_cmd(input string tag, input logic exp_err);
        chk({tag, "_done"}, 64'(done_o), 64'(1));
        chk({tag, "_error"}, 64'(error_o), 64'(exp_err));
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'(1));
        idle_inputs();
        @(posedge clk_i); #1;
        chk({tag, "_done_pulse"}, 64'(done_o), 64'(0));
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input int rlast_at, input int bad_at);
        int beats, nb;
        logic ar_done, fin, hs, exp_err;
        logic [32:0] e;
        beats   = (rlast_at < int'(len)) ? rlast_at + 1 : int'(len) + 1;
        exp_err = (rlast_at != int'(len)) || (bad_at < beats);
        issue(1'b0, addr, len, id);
        ar_done = 0; fin = 0; nb = 0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            axi_arready_i = !ar_done && ($urandom_range(0, 2) != 0);
            axi_rvalid_i  = ar_done ? ($urandom_range(0, 3) != 0) : 1'b1;
            axi_rdata_i   = rdat(id, nb);
            axi_rlast_i   = (nb == rlast_at);
            axi_rresp_i   = (nb == bad_at) ? 2'b10 : 2'b00;
            axi_rid_i     = id;
            rd_ready_i    = ar_done ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk_i);
            hs = 0;
            if (!ar_done) begin
                chk("r_blocked_rready", 64'(axi_rready_o), 64'(0));
                chk("r_blocked_rdvalid", 64'(rd_valid_o), 64'(0));
                if (axi_arvalid_o && axi_arready_i) begin
                    chk("araddr", 64'(axi_araddr_o), 64'(addr));
                    chk("arlen", 64'(axi_arlen_o), 64'(len));
                    chk("arid", 64'(axi_arid_o), 64'(id));
                    hs = 1;
                    for (int i = 0; i < beats; i++) rq.push_back({(i == int'(len)), rdat(id, i)});
                end
            end else begin
                chk("rready_pass", 64'(axi_rready_o), 64'(rd_ready_i));
                if (rd_valid_o && rd_ready_i) begin
                    hs = 1;
                    if (rq.size() == 0) chk("r_extra_beat", 64'(1), 64'(0));
                    else begin
                        e = rq.pop_front();
                        chk("rd_data", 64'(rd_data_o), 64'(e[31:0]));
                        chk("rd_last", 64'(rd_last_o), 64'(e[32]));
                    end
                end
            end
            @(posedge clk_i); #1;
            if (hs) begin
                if (!ar_done) ar_done = 1;
                else begin
                    fin = (nb == int'(len)) || axi_rlast_i;
                    nb++;
                end
            end
        end
        chk("r_timeout", 64'(fin), 64'(1));
        chk("r_left", 64'(rq.size()), 64'(0));
        rq.delete();
        finish_cmd("rd", exp_err);
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                             input logic [3:0] bid, input logic [1:0] bresp, input logic toggle,
                             input int abort_at);
        int nw;
        logic aw_done, fin, hs, wv;
        logic [36:0] e;
        issue(1'b1, addr, len, id);
        for (int i = 0; i <= int'(len); i++) wq.push_back({(i == int'(len)), wstb(i), wdat(i)});
        aw_done = 0; fin = 0; nw = 0; wv = 0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            axi_awready_i = !aw_done && ($urandom_range(0, 2) != 0);
            wv            = toggle ? !wv : 1'b1;
            wr_valid_i    = aw_done ? wv : 1'b1;
            wr_data_i     = wdat(nw);
            wr_strb_i     = wstb(nw);
            axi_wready_i  = aw_done ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk_i);
            hs = 0;
            if (!aw_done) begin
                chk("w_before_aw", 64'(axi_wvalid_o), 64'(0));
                chk("wr_ready_before_aw", 64'(wr_ready_o), 64'(0));
                if (axi_awvalid_o && axi_awready_i) begin
                    chk("awaddr", 64'(axi_awaddr_o), 64'(addr));
                    chk("awlen", 64'(axi_awlen_o), 64'(len));
                    chk("awid", 64'(axi_awid_o), 64'(id));
                    hs = 1;
                end
            end else begin
                chk("wvalid_pass", 64'(axi_wvalid_o), 64'(wr_valid_i));
                chk("wr_ready_pass", 64'(wr_ready_o), 64'(axi_wready_i));
                if (axi_wvalid_o && axi_wready_i) begin
                    hs = 1;
                    if (wq.size() == 0) chk("w_extra_beat", 64'(1), 64'(0));
                    else begin
                        e = wq.pop_front();
                        chk("wdata", 64'(axi_wdata_o), 64'(e[31:0]));
                        chk("wstrb", 64'(axi_wstrb_o), 64'(e[35:32]));
                        chk("wlast", 64'(axi_wlast_o), 64'(e[36]));
                    end
                end
            end
            @(posedge clk_i); #1;
            if (hs) begin
                if (!aw_done) aw_done = 1;
                else nw++;
            end
            fin = (nw == int'(len) + 1) || (abort_at != 0 && nw == abort_at);
        end
        chk("w_timeout", 64'(fin), 64'(1));
        if (abort_at != 0) begin
            rst_i = 1;
            @(posedge clk_i); #1;
            rst_i = 0;
            wr_valid_i = 1;
            @(negedge clk_i);
            chk("rst_awvalid", 64'(axi_awvalid_o), 64'(0));
            chk("rst_wvalid", 64'(axi_wvalid_o), 64'(0));
            chk("rst_arvalid", 64'(axi_arvalid_o), 64'(0));
            chk("rst_bready", 64'(axi_bready_o), 64'(0));
            chk("rst_req_ready", 64'(req_ready_o), 64'(1));
            chk("rst_busy", 64'(busy_o), 64'(0));
            wq.delete();
            idle_inputs();
            @(posedge clk_i); #1;
            return;
        end
        chk("w_left", 64'(wq.size()), 64'(0));
        wq.delete();
        for (int i = 0; i < int'($urandom_range(1, 2)); i++) begin
            wr_valid_i = 1;
            @(negedge clk_i);
            chk("bready_wait", 64'(axi_bready_o), 64'(1));
            chk("w_after_last", 64'(axi_wvalid_o), 64'(0));
            chk("done_before_b", 64'(done_o), 64'(0));
            @(posedge clk_i); #1;
        end
        axi_bvalid_i = 1; axi_bid_i = bid; axi_bresp_i = bresp;
        @(negedge clk_i);
        chk("bready_hs", 64'(axi_bready_o), 64'(1));
        @(posedge clk_i); #1;
        axi_bvalid_i = 0;
        finish_cmd("wr", (bid != id) || (bresp != 2'b00));
    endtask

    initial begin
        idle_inputs();
        rst_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 0;
        @(negedge clk_i);
        chk("reset_req_ready", 64'(req_ready_o), 64'(1));
        chk("reset_busy", 64'(busy_o), 64'(0));
        chk("reset_arvalid", 64'(axi_arvalid_o), 64'(0));
        chk("reset_awvalid", 64'(axi_awvalid_o), 64'(0));
        chk("reset_bready", 64'(axi_bready_o), 64'(0));
        chk("reset_done", 64'(done_o), 64'(0));
        @(posedge clk_i); #1;

        run_read(32'h8000_0000, 8'd3, 4'd5, 3, 99);
        run_write(32'h8000_0100, 8'd0, 4'd2, 4'd2, 2'b00, 1'b0, 0);
        run_write(32'h8000_1000, 8'd255, 4'd3, 4'd3, 2'b00, 1'b1, 0);
        run_read(32'h8000_2000, 8'd7, 4'd1, 4, 99);
        run_read(32'h8000_3000, 8'd3, 4'd6, 3, 1);
        run_read(32'h8000_3800, 8'd2, 4'd7, 5, 99);
        run_write(32'h8000_4000, 8'd2, 4'd4, 4'd9, 2'b00, 1'b0, 0);
        run_write(32'h8000_5000, 8'd7, 4'd1, 4'd1, 2'b00, 1'b0, 3);
        run_read(32'h8000_6000, 8'd1, 4'd2, 1, 99);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_axi_master.md
# sdram_axi_master

AXI4 burst initiator that converts a simple command/stream interface into AXI4 read and write bursts. It targets the SDRAM AXI4 slave port and drives AW, W, B, AR and R from the master side. Each command is carried through to completion before the next one is accepted. The block is the reusable front end for DMA and test-traffic engines in the SDRAM subsystem.

## Interface
- `ID_W`, default 4: AXI ID width.
- `clk_i` in 1: single clock; all logic is on its rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `req_valid_i` in 1 / `req_ready_o` out 1: command handshake.
- `req_write_i` in 1: 1 selects a write burst, 0 selects a read burst.
- `req_addr_i` in 32: burst start address, byte address, 4-byte aligned.
- `req_len_i` in 8: AXI len encoding, beats minus 1.
- `req_burst_i` in 2: AXI burst type, passed through unchanged.
- `req_id_i` in ID_W: transaction ID.
- `wr_valid_i` in 1, `wr_data_i` in 32, `wr_strb_i` in 4 / `wr_ready_o` out 1: write data stream.
- `rd_valid_o` out 1, `rd_data_o` out 32, `rd_last_o` out 1 / `rd_ready_i` in 1: read data stream.
- `done_o` out 1: one-cycle pulse when a command completes.
- `error_o` out 1: valid with `done_o`.
- `busy_o` out 1: high whenever state is not IDLE.
- AXI master ports, standard AXI4 meaning:
  - `axi_awvalid_o`, `axi_awaddr_o`[32], `axi_awid_o`[ID_W], `axi_awlen_o`[8], `axi_awburst_o`[2], `axi_awready_i`.
  - `axi_wvalid_o`, `axi_wdata_o`[32], `axi_wstrb_o`[4], `axi_wlast_o`, `axi_wready_i`.
  - `axi_bvalid_i`, `axi_bresp_i`[2], `axi_bid_i`[ID_W], `axi_bready_o`.
  - `axi_arvalid_o`, `axi_araddr_o`[32], `axi_arid_o`[ID_W], `axi_arlen_o`[8], `axi_arburst_o`[2], `axi_arready_i`.
  - `axi_rvalid_i`, `axi_rdata_i`[32], `axi_rresp_i`[2], `axi_rid_i`[ID_W], `axi_rlast_i`, `axi_rready_o`.

## Operation
- States: IDLE, AR, R, AW, W, B.
- `req_ready_o` = (state==IDLE).
- On command accept the block captures addr, len, burst and id into registers and loads the beat counter `cnt_q` with `req_len_i`.
  - Read: go to AR.
  - Write: go to AW.
- AR: `axi_arvalid_o` is held high with stable fields until `axi_arready_i`; then go to R.
- R:
  - `axi_rready_o` = `rd_ready_i`.
  - `rd_valid_o` = `axi_rvalid_i`; `rd_data_o` = `axi_rdata_i`.
  - `rd_last_o` = `axi_rvalid_i` & (`cnt_q`==0).
  - Each R handshake decrements `cnt_q`.
  - The burst ends on the handshake where `cnt_q`==0 or `axi_rlast_i`=1, whichever comes first; then go to IDLE.
- AW: `axi_awvalid_o` is held high until `axi_awready_i`; then go to W. AW always completes before the first W beat is presented; the slave depends on this ordering.
- W:
  - `axi_wvalid_o` = `wr_valid_i`; `wr_ready_o` = `axi_wready_i`.
  - `axi_wlast_o` = (`cnt_q`==0).
  - Each W handshake decrements `cnt_q`.
  - The handshake with `cnt_q`==0 moves to B.
- B: `axi_bready_o` = 1 (registered). On the B handshake go to IDLE.
- Error flag `err_q`:
  - Cleared on command accept.
  - Set by any nonzero `axi_rresp_i` or `axi_bresp_i` on a handshake.
  - Set by `axi_rid_i` or `axi_bid_i` differing from the captured id.
  - Set by early `axi_rlast_i` (asserted while `cnt_q`!=0).
  - Set by missing rlast (`cnt_q`==0 while `axi_rlast_i`=0).
- Outside R, `rd_valid_o` and `axi_rready_o` are 0. Outside W, `wr_ready_o` and `axi_wvalid_o` are 0.
- R beats arriving outside R are not accepted; `axi_rready_o` stays 0.
- The block does not increment addresses; the slave computes burst addresses.

## Timing
- Reset values: every output is 0 except `req_ready_o`=1. State returns to IDLE and `cnt_q`, `err_q` clear.
- A reset mid-burst abandons the burst. Valids drop in the next cycle.
- Command accepted in cycle N: `axi_arvalid_o` or `axi_awvalid_o` is high in cycle N+1. These are registered outputs with no combinational path from `req_valid_i`.
- Final handshake (last R, or B) in cycle K:
  - `done_o`=1 and `error_o`=`err_q` (including any error raised on the final beat) in cycle K+1.
  - `req_ready_o`=1 in cycle K+1.
  - The earliest next command is accepted in cycle K+1.
- R and W data paths are combinational pass-throughs: zero added latency and full throughput of 1 beat/cycle.
- Minimum read command: 1 cycle AR, 1 cycle R, done at +3 cycles from accept when the slave responds immediately.
- len=255 gives 256 beats; `cnt_q` never wraps below 0 because the burst exits at 0.

## Test plan
- Read, addr 0x8000_0000, len 3, INCR, id 5; slave returns 4 beats D0..D3 with rlast on beat 3 -> `rd_last_o` only on beat 3; `done_o`=1 with `error_o`=0 one cycle after beat 3; `axi_arvalid_o` high exactly 1 cycle after accept.
- Write, len 0, strb 0xF -> single W beat with `axi_wlast_o`=1; AW handshake precedes W; `bready` high until B; `done_o` one cycle after B.
- Write, len 255 with `wr_valid_i` toggling every cycle and `axi_wready_i` random -> exactly 256 W handshakes, `axi_wlast_o` only on the 256th, data order preserved.
- Read, len 7; slave asserts rlast on beat 4 -> burst ends after 5 beats, `error_o`=1.
- Read with `axi_rresp_i`=2'b10 on beat 1 -> all beats are delivered and `error_o`=1 at done. Write with `axi_bid_i` not equal to `req_id_i` -> `error_o`=1.
- Assert `rst_i` for 1 cycle during a W burst -> next cycle all AXI valids are 0 and `req_ready_o`=1; a new read then completes normally.
